traffic_phase_scheduler: RTL and testbench

TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

---
 rtl/traffic_phase_scheduler.sv | 150 +++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// Two-road traffic controller with a pedestrian phase, written as a Moore FSM.
// Every timing decision is made on tick strobes, and the lamps are decoded from the state register only.
module traffic_phase_scheduler #(
    parameter int T_GREEN_MIN = 4,
    parameter int T_GREEN_MAX = 12,
    parameter int T_YELLOW    = 4,
    parameter int T_ALLRED    = 1,
    parameter int T_WALK      = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       veh_a,
    input  logic       veh_b,
    input  logic       ped_btn,
    output logic [2:0] RGB1,
    output logic [2:0] RGB2,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        A_GRN   = 3'd0,
        A_YEL   = 3'd1,
        AR_A    = 3'd2,
        B_GRN   = 3'd3,
        B_YEL   = 3'd4,
        AR_B    = 3'd5,
        PED     = 3'd6,
        ILLEGAL = 3'd7
    } state_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_GREEN  = 3'b010;
    localparam logic [2:0] LAMP_YELLOW = 3'b110;

    localparam logic [5:0] N_GMIN = 6'(T_GREEN_MIN);
    localparam logic [5:0] N_GMAX = 6'(T_GREEN_MAX);
    localparam logic [5:0] N_YEL  = 6'(T_YELLOW);
    localparam logic [5:0] N_AR   = 6'(T_ALLRED);
    localparam logic [5:0] N_WALK = 6'(T_WALK);

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic       last_q, last_d;
    logic       req_a_q, req_a_d;
    logic       req_b_q, req_b_d;
    logic       req_p_q, req_p_d;

    // n includes the tick being processed now. It is one bit wider so that a saturated count still compares correctly.
    logic [5:0] n;
    assign n = {1'b0, cnt_q} + 6'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= AR_B;
            cnt_q   <= 5'd0;
            last_q  <= 1'b1;
            req_a_q <= 1'b0;
            req_b_q <= 1'b0;
            req_p_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            req_a_q <= req_a_d;
            req_b_q <= req_b_d;
            req_p_q <= req_p_d;
        end
    end

    // This block computes the next state and decodes the lamps.
    always_comb begin
        state_d = state_q;
        RGB1    = LAMP_RED;
        RGB2    = LAMP_RED;
        walk    = 1'b0;
        phase   = state_q;

        case (state_q)
            A_GRN: begin
                RGB1 = LAMP_GREEN;
                if (tick && (n >= N_GMIN) && (req_b_q || req_p_q) &&
                    (!veh_a || (n >= N_GMAX)))
                    state_d = A_YEL;
            end
            A_YEL: begin
                RGB1 = LAMP_YELLOW;
                if (tick && (n >= N_YEL))
                    state_d = AR_A;
            end
            AR_A: begin
                if (tick && (n >= N_AR))
                    state_d = req_p_q ? PED : B_GRN;
            end
            B_GRN: begin
                RGB2 = LAMP_GREEN;
                if (tick && (n >= N_GMIN) && (req_a_q || req_p_q) &&
                    (!veh_b || (n >= N_GMAX)))
                    state_d = B_YEL;
            end
            B_YEL: begin
                RGB2 = LAMP_YELLOW;
                if (tick && (n >= N_YEL))
                    state_d = AR_B;
            end
            AR_B: begin
                if (tick && (n >= N_AR))
                    state_d = req_p_q ? PED : A_GRN;
            end
            PED: begin
                walk = 1'b1;
                // Hand over to the road that did not have the last green. The all-red was already served before the walk.
                if (tick && (n >= N_WALK))
                    state_d = last_q ? A_GRN : B_GRN;
            end
            default: begin
                state_d = AR_B;
            end
        endcase
    end

    // This block updates the counter, the demand latches and the last-road flag.
    always_comb begin
        cnt_d   = cnt_q;
        last_d  = last_q;
        req_a_d = req_a_q | (veh_a   && (state_q != A_GRN));
        req_b_d = req_b_q | (veh_b   && (state_q != B_GRN));
        req_p_d = req_p_q | (ped_btn && (state_q != PED));

        if (state_d != state_q)
            cnt_d = 5'd0;
        else if (tick && (cnt_q != 5'd31))
            cnt_d = cnt_q + 5'd1;

        if ((state_q == A_YEL) && (state_d != A_YEL))
            last_d = 1'b0;
        else if ((state_q == B_YEL) && (state_d != B_YEL))
            last_d = 1'b1;

        // When a phase is entered, its latch is cleared. The clear wins over a set on the same clk.
        if ((state_d == A_GRN) && (state_q != A_GRN))
            req_a_d = 1'b0;
        if ((state_d == B_GRN) && (state_q != B_GRN))
            req_b_d = 1'b0;
        if ((state_d == PED) && (state_q != PED))
            req_p_d = 1'b0;
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with hand-computed phase and lamp expectations.
// Inputs are driven 1 time unit after each rising edge, and outputs are sampled at the same point.
module tb_traffic_phase_scheduler;

    logic       clk;
    logic       reset_n;
    logic       tick;
    logic       veh_a;
    logic       veh_b;
    logic       ped_btn;
    logic [2:0] RGB1;
    logic [2:0] RGB2;
    logic       walk;
    logic [2:0] phase;

    int tests = 0;
    int fails = 0;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] GRN = 3'b010;
    localparam logic [2:0] YEL = 3'b110;

    traffic_phase_scheduler dut (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .veh_a   (veh_a),
        .veh_b   (veh_b),
        .ped_btn (ped_btn),
        .RGB1    (RGB1),
        .RGB2    (RGB2),
        .walk    (walk),
        .phase   (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk_cycle(input logic t);
        tick = t;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    // Each tick is preceded by three idle clks, so ticks arrive every 4 clks.
    task automatic run_ticks(input int k);
        repeat (k) begin
            repeat (3) clk_cycle(1'b0);
            clk_cycle(1'b1);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        tick    = 1'b0;
        veh_a   = 1'b0;
        veh_b   = 1'b0;
        ped_btn = 1'b1;
        @(posedge clk);
        #1;
        // While reset is held, ticks and inputs must be ignored.
        repeat (3) clk_cycle(1'b1);
        check("rst_phase", 8'(phase), 8'd5);
        check("rst_rgb1", 8'(RGB1), 8'(RED));
        check("rst_rgb2", 8'(RGB2), 8'(RED));
        check("rst_walk", 8'(walk), 8'd0);
        check("rst_req_p", 8'(dut.req_p_q), 8'd0);
        check("rst_cnt", 8'(dut.cnt_q), 8'd0);
        check("rst_last", 8'(dut.last_q), 8'd1);

        reset_n = 1'b1;
        ped_btn = 1'b0;
        repeat (3) clk_cycle(1'b0);
        check("pwr_allred", 8'(phase), 8'd5);
        clk_cycle(1'b1);
        check("pwr_a_grn", 8'(phase), 8'd0);
        check("pwr_rgb1", 8'(RGB1), 8'(GRN));
        check("pwr_rgb2", 8'(RGB2), 8'(RED));
        run_ticks(50);
        check("rest_a_grn", 8'(phase), 8'd0);
        check("rest_cnt_sat", 8'(dut.cnt_q), 8'd31);

        // A veh_b pulse while A_GRN is saturated causes A to yield on the next tick.
        veh_b = 1'b1;
        clk_cycle(1'b0);
        veh_b = 1'b0;
        run_ticks(1);
        check("sat_a_yel", 8'(phase), 8'd1);
        check("sat_rgb1_yel", 8'(RGB1), 8'(YEL));
        check("sat_req_b", 8'(dut.req_b_q), 8'd1);
        run_ticks(3);
        check("yel_hold", 8'(phase), 8'd1);
        run_ticks(1);
        check("ar_a", 8'(phase), 8'd2);
        check("ar_a_rgb1", 8'(RGB1), 8'(RED));
        check("last_a", 8'(dut.last_q), 8'd0);
        run_ticks(1);
        check("b_grn", 8'(phase), 8'd3);
        check("b_grn_rgb2", 8'(RGB2), 8'(GRN));
        check("b_req_b_clr", 8'(dut.req_b_q), 8'd0);

        // ped_btn and veh_a arrive on the same clk early in B_GRN. The minimum green must still be served.
        ped_btn = 1'b1;
        veh_a   = 1'b1;
        clk_cycle(1'b0);
        ped_btn = 1'b0;
        veh_a   = 1'b0;
        run_ticks(3);
        check("b_min_hold", 8'(phase), 8'd3);
        run_ticks(1);
        check("b_yel", 8'(phase), 8'd4);
        check("b_yel_rgb2", 8'(RGB2), 8'(YEL));
        check("b_yel_rgb1", 8'(RGB1), 8'(RED));
        run_ticks(4);
        check("ar_b", 8'(phase), 8'd5);
        check("last_b", 8'(dut.last_q), 8'd1);
        run_ticks(1);
        check("ped", 8'(phase), 8'd6);
        check("ped_walk", 8'(walk), 8'd1);
        check("ped_rgb1", 8'(RGB1), 8'(RED));
        check("ped_rgb2", 8'(RGB2), 8'(RED));
        check("ped_req_clr", 8'(dut.req_p_q), 8'd0);
        run_ticks(5);
        check("ped_hold", 8'(phase), 8'd6);
        run_ticks(1);
        check("ped_to_a", 8'(phase), 8'd0);
        check("ped_to_a_walk", 8'(walk), 8'd0);
        check("a_req_a_clr", 8'(dut.req_a_q), 8'd0);

        // With veh_a held high, A_GRN extends to the maximum green.
        veh_a = 1'b1;
        veh_b = 1'b1;
        run_ticks(11);
        check("ext_hold11", 8'(phase), 8'd0);
        run_ticks(1);
        check("ext_yel12", 8'(phase), 8'd1);
        clk_cycle(1'b0);
        veh_a = 1'b0;
        veh_b = 1'b0;
        check("yel_sets_req_a", 8'(dut.req_a_q), 8'd1);
        run_ticks(5);
        check("ext_b_grn", 8'(phase), 8'd3);
        run_ticks(4);
        check("b_min_yield", 8'(phase), 8'd4);
        run_ticks(5);
        check("back_a_grn", 8'(phase), 8'd0);

        // A veh_b pulse on the first tick of a fresh A_GRN.
        veh_b = 1'b1;
        clk_cycle(1'b1);
        veh_b = 1'b0;
        run_ticks(2);
        check("t1_hold", 8'(phase), 8'd0);
        check("t1_req_b", 8'(dut.req_b_q), 8'd1);
        run_ticks(1);
        check("t1_yel", 8'(phase), 8'd1);
        run_ticks(3);
        check("t1_yel_hold", 8'(phase), 8'd1);
        run_ticks(1);
        check("t1_ar_a", 8'(phase), 8'd2);
        run_ticks(1);
        check("t1_b_grn", 8'(phase), 8'd3);
        check("t1_req_b_clr", 8'(dut.req_b_q), 8'd0);

        // Reset is asserted between clock edges while the walk phase is active.
        ped_btn = 1'b1;
        clk_cycle(1'b0);
        ped_btn = 1'b0;
        run_ticks(4);
        check("m_b_yel", 8'(phase), 8'd4);
        run_ticks(5);
        check("m_ped", 8'(phase), 8'd6);
        run_ticks(2);
        ped_btn = 1'b1;
        clk_cycle(1'b0);
        check("ped_no_set", 8'(dut.req_p_q), 8'd0);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_phase", 8'(phase), 8'd5);
        check("async_walk", 8'(walk), 8'd0);
        check("async_rgb1", 8'(RGB1), 8'(RED));
        check("async_rgb2", 8'(RGB2), 8'(RED));
        @(posedge clk);
        #1;
        repeat (2) clk_cycle(1'b1);
        check("mid_rst_req_p", 8'(dut.req_p_q), 8'd0);
        check("mid_rst_phase", 8'(phase), 8'd5);
        reset_n = 1'b1;
        ped_btn = 1'b0;
        run_ticks(1);
        check("resume_a_grn", 8'(phase), 8'd0);

        // A ped_btn press after reset release leads to PED, and the walk then exits to A_GRN because last=1.
        reset_n = 1'b0;
        clk_cycle(1'b0);
        reset_n = 1'b1;
        ped_btn = 1'b1;
        clk_cycle(1'b0);
        ped_btn = 1'b0;
        run_ticks(1);
        check("rel_ped", 8'(phase), 8'd6);
        check("rel_ped_walk", 8'(walk), 8'd1);
        run_ticks(5);
        check("rel_ped_hold", 8'(phase), 8'd6);
        run_ticks(1);
        check("rel_ped_to_a", 8'(phase), 8'd0);

        // With tick held high continuously, each phase lasts as many clks as its parameter.
        veh_b = 1'b1;
        tick  = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            logic [2:0] exp_ph;
            @(posedge clk);
            #1;
            if (k < 4)      exp_ph = 3'd0;
            else if (k < 8) exp_ph = 3'd1;
            else if (k < 9) exp_ph = 3'd2;
            else            exp_ph = 3'd3;
            check($sformatf("cont_clk%0d", k), 8'(phase), 8'(exp_ph));
        end
        tick  = 1'b0;
        veh_b = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
